mult_hazard_ctrl: RTL and testbench
===================================

MULT_HAZARD_CTRL -- requirements
Module: mult_hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_ADDR_W, default 5, register-address width.
REQ-002 SHALL have parameter MULT_LATENCY, default 4, EX cycles a multiply occupies; legal range 2..15.
REQ-003 SHALL have clk  input  1  single clock, all state rising-edge.
REQ-004 SHALL have arst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have ex_valid  input  1  EX stage holds a real instruction (not a bubble).
REQ-006 SHALL have ex_is_mult  input  1  EX instruction is a multiply.
REQ-007 SHALL have ex_mem_read  input  1  EX instruction is a load.
REQ-008 SHALL have ex_rd, ex_rs1, ex_rs2  input  REG_ADDR_W each  EX destination and source registers.
REQ-009 SHALL have id_rs1, id_rs2  input  REG_ADDR_W each  ID source registers.
REQ-010 SHALL have mem_rd, wb_rd  input  REG_ADDR_W each; mem_reg_write, wb_reg_write  input  1 each  later-stage writeback info.
REQ-011 SHALL have fwd_sel_a, fwd_sel_b  output  2 each  select for EX operand 3:1 muxes (00 regfile, 01 MEM, 10 WB).
REQ-012 SHALL have stall  output  1  hold PC, IF/ID and ID/EX registers.
REQ-013 SHALL have id_ex_flush  output  1  load bubble into ID/EX.
REQ-014 SHALL have ex_mem_bubble  output  1  load bubble into EX/MEM.
REQ-015 SHALL have mult_start, mult_done  output  1 each  multiplier launch pulse / result-valid pulse.
REQ-016 SHALL have mult_busy  output  1  high in every non-IDLE state.

Function
REQ-017 Forwarding SHALL be combinational: fwd_sel_a=01 if mem_reg_write, mem_rd!=0 and mem_rd==ex_rs1; else 10 if wb_reg_write, wb_rd!=0 and wb_rd==ex_rs1; else 00; fwd_sel_b identically on ex_rs2.
REQ-018 MEM match SHALL take priority over WB match; register 0 SHALL never forward; encoding 11 SHALL never be driven.
REQ-019 FSM states SHALL be IDLE, BUSY, DONE.
REQ-020 IDLE with ex_valid & ex_is_mult SHALL drive mult_start=1, stall=1, ex_mem_bubble=1 that cycle and move to BUSY (MULT_LATENCY>2) or DONE (MULT_LATENCY=2).
REQ-021 BUSY SHALL drive stall=1, ex_mem_bubble=1 and hold for MULT_LATENCY-2 cycles via down-counter, then move to DONE.
REQ-022 DONE SHALL drive mult_done=1, stall=0, ex_mem_bubble=0 for one cycle, then move to IDLE.
REQ-023 A multiply SHALL therefore occupy EX exactly MULT_LATENCY cycles, with stall high for the first MULT_LATENCY-1.
REQ-024 A multiply entering EX the cycle after DONE SHALL start immediately (back-to-back, no idle gap).
REQ-025 Load-use: in IDLE, ex_valid & ex_mem_read & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2) SHALL drive stall=1 and id_ex_flush=1 for one cycle.
REQ-026 id_ex_flush SHALL be 0 whenever the FSM is not IDLE; load-use SHALL NOT be evaluated outside IDLE.
REQ-027 ex_is_mult and ex_mem_read both high SHALL be treated as multiply (multiply wins).
REQ-028 ex_valid=0 SHALL suppress mult start and load-use detection.
REQ-029 Counter SHALL be ceil(log2(MULT_LATENCY)) bits minimum and never wrap below 0.

Reset
REQ-030 arst_n low SHALL immediately force state IDLE, counter 0, and all outputs except fwd_sel_a/b to 0.
REQ-031 Reset asserted mid-multiply SHALL abandon the operation; no mult_done SHALL follow release.
REQ-032 First cycle after release SHALL evaluate inputs as normal IDLE.

Structure
REQ-033 Shared package SHALL hold FWD_RF/FWD_MEM/FWD_WB encodings and the FSM state encoding.
REQ-034 Forwarding logic SHALL be a sub-module, forwarding_unit; FSM, counter and load-use logic SHALL stay in the top.

Verification
REQ-035 mem_reg_write=1, mem_rd=5, wb_reg_write=1, wb_rd=5, ex_rs1=5 -> fwd_sel_a=01; mem_rd=0, wb_rd=0 with ex_rs1=0 -> 00.
REQ-036 Multiply in EX at cycle T, MULT_LATENCY=4 -> mult_start at T, stall T..T+2, mult_done at T+3, stall=0 at T+3.
REQ-037 Two consecutive multiplies -> second mult_start at T+4, mult_done at T+7.
REQ-038 Load ex_rd=7, id_rs2=7 -> one cycle stall=1, id_ex_flush=1; ex_rd=0 -> no stall.
REQ-039 arst_n low at T+1 of a multiply -> outputs 0 immediately, state IDLE, no mult_done after release.
REQ-040 MULT_LATENCY=2 -> mult_start at T (stall=1), mult_done at T+1, back in IDLE at T+2.

Source files
------------

// File: rtl/mult_hazard_ctrl_pkg.sv
// Shared encodings for the multiply/hazard controller.
package mult_hazard_ctrl_pkg;

   localparam int unsigned FWD_W = 2;

   // EX operand mux select
   typedef enum logic [FWD_W-1:0] {
      FWD_RF  = 2'b00,
      FWD_MEM = 2'b01,
      FWD_WB  = 2'b10
   } fwd_sel_e;

   // Multiply sequencing states
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10
   } state_e;

   // Down-counter width for a given multiply latency (at least one bit)
   function automatic int unsigned cnt_width(input int unsigned lat);
      return (lat < 2) ? 1 : $clog2(lat);
   endfunction

endpackage

// File: rtl/mult_hazard_ctrl_if.sv
// Pipeline-side signals seen by the hazard controller.
interface mult_hazard_ctrl_if #(
   parameter int unsigned REG_ADDR_W = 5
);
   logic                  ex_valid;
   logic                  ex_is_mult;
   logic                  ex_mem_read;
   logic [REG_ADDR_W-1:0] ex_rd;
   logic [REG_ADDR_W-1:0] ex_rs1;
   logic [REG_ADDR_W-1:0] ex_rs2;
   logic [REG_ADDR_W-1:0] id_rs1;
   logic [REG_ADDR_W-1:0] id_rs2;
   logic [REG_ADDR_W-1:0] mem_rd;
   logic [REG_ADDR_W-1:0] wb_rd;
   logic                  mem_reg_write;
   logic                  wb_reg_write;
   logic [1:0]            fwd_sel_a;
   logic [1:0]            fwd_sel_b;
   logic                  stall;
   logic                  id_ex_flush;
   logic                  ex_mem_bubble;
   logic                  mult_start;
   logic                  mult_done;
   logic                  mult_busy;

   // Pipeline drives stage info, consumes control
   modport master (
      output ex_valid, ex_is_mult, ex_mem_read, ex_rd, ex_rs1, ex_rs2,
             id_rs1, id_rs2, mem_rd, wb_rd, mem_reg_write, wb_reg_write,
      input  fwd_sel_a, fwd_sel_b, stall, id_ex_flush, ex_mem_bubble,
             mult_start, mult_done, mult_busy
   );

   // Controller consumes stage info, drives control
   modport slave (
      input  ex_valid, ex_is_mult, ex_mem_read, ex_rd, ex_rs1, ex_rs2,
             id_rs1, id_rs2, mem_rd, wb_rd, mem_reg_write, wb_reg_write,
      output fwd_sel_a, fwd_sel_b, stall, id_ex_flush, ex_mem_bubble,
             mult_start, mult_done, mult_busy
   );
endinterface

// File: rtl/mult_hazard_ctrl_forwarding_unit.sv
// Combinational EX operand forwarding; MEM beats WB, x0 never forwards.
module forwarding_unit
   import mult_hazard_ctrl_pkg::*;
#(
   parameter int unsigned REG_ADDR_W = 5
) (
   input  logic [REG_ADDR_W-1:0] ex_rs1,
   input  logic [REG_ADDR_W-1:0] ex_rs2,
   input  logic [REG_ADDR_W-1:0] mem_rd,
   input  logic [REG_ADDR_W-1:0] wb_rd,
   input  logic                  mem_reg_write,
   input  logic                  wb_reg_write,
   output fwd_sel_e              fwd_sel_a,
   output fwd_sel_e              fwd_sel_b
);

   logic mem_hit_a, mem_hit_b, wb_hit_a, wb_hit_b;

   // Match a source register against each later-stage writer
   always_comb begin
      mem_hit_a = mem_reg_write && (mem_rd != '0) && (mem_rd == ex_rs1);
      mem_hit_b = mem_reg_write && (mem_rd != '0) && (mem_rd == ex_rs2);
      wb_hit_a  = wb_reg_write  && (wb_rd  != '0) && (wb_rd  == ex_rs1);
      wb_hit_b  = wb_reg_write  && (wb_rd  != '0) && (wb_rd  == ex_rs2);
   end

   // Priority select: youngest producer wins
   always_comb begin
      fwd_sel_a = FWD_RF;
      fwd_sel_b = FWD_RF;
      if (mem_hit_a)     fwd_sel_a = FWD_MEM;
      else if (wb_hit_a) fwd_sel_a = FWD_WB;
      if (mem_hit_b)     fwd_sel_b = FWD_MEM;
      else if (wb_hit_b) fwd_sel_b = FWD_WB;
   end

endmodule

// File: rtl/mult_hazard_ctrl.sv
// Multi-cycle multiply sequencing, load-use stall and forwarding control.
module mult_hazard_ctrl
   import mult_hazard_ctrl_pkg::*;
#(
   parameter int unsigned REG_ADDR_W   = 5,
   parameter int unsigned MULT_LATENCY = 4
) (
   input logic               clk,
   input logic               arst_n,
   mult_hazard_ctrl_if.slave bus
);

   localparam int unsigned CNT_W    = cnt_width(MULT_LATENCY);
   // BUSY lasts MULT_LATENCY-2 cycles; counter runs from that minus one down to 0
   localparam int unsigned CNT_LOAD = (MULT_LATENCY > 3) ? (MULT_LATENCY - 3) : 0;

   state_e         state;
   logic [CNT_W-1:0] cnt;
   logic           mult_go;
   logic           load_use;
   fwd_sel_e       fsel_a, fsel_b;

   forwarding_unit #(
      .REG_ADDR_W (REG_ADDR_W)
   ) u_fwd (
      .ex_rs1        (bus.ex_rs1),
      .ex_rs2        (bus.ex_rs2),
      .mem_rd        (bus.mem_rd),
      .wb_rd         (bus.wb_rd),
      .mem_reg_write (bus.mem_reg_write),
      .wb_reg_write  (bus.wb_reg_write),
      .fwd_sel_a     (fsel_a),
      .fwd_sel_b     (fsel_b)
   );

   assign bus.fwd_sel_a = 2'(fsel_a);
   assign bus.fwd_sel_b = 2'(fsel_b);

   // Hazard requests from the EX instruction; multiply overrides load
   always_comb begin
      mult_go  = bus.ex_valid && bus.ex_is_mult;
      load_use = bus.ex_valid && !bus.ex_is_mult && bus.ex_mem_read &&
                 (bus.ex_rd != '0) &&
                 ((bus.ex_rd == bus.id_rs1) || (bus.ex_rd == bus.id_rs2));
   end

   // State and latency counter
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (mult_go) begin
                  if (MULT_LATENCY > 2) begin
                     state <= BUSY;
                     cnt   <= CNT_W'(CNT_LOAD);
                  end else begin
                     state <= DONE;
                  end
               end
            end
            BUSY: begin
               if (cnt == '0) state <= DONE;
               else           cnt   <= cnt - CNT_W'(1);
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Control outputs; same-cycle response in IDLE, all held low in reset
   always_comb begin
      bus.stall         = 1'b0;
      bus.id_ex_flush   = 1'b0;
      bus.ex_mem_bubble = 1'b0;
      bus.mult_start    = 1'b0;
      bus.mult_done     = 1'b0;
      bus.mult_busy     = 1'b0;
      if (arst_n) begin
         case (state)
            IDLE: begin
               if (mult_go) begin
                  bus.mult_start    = 1'b1;
                  bus.stall         = 1'b1;
                  bus.ex_mem_bubble = 1'b1;
               end else if (load_use) begin
                  bus.stall         = 1'b1;
                  bus.id_ex_flush   = 1'b1;
               end
            end
            BUSY: begin
               bus.stall         = 1'b1;
               bus.ex_mem_bubble = 1'b1;
               bus.mult_busy     = 1'b1;
            end
            DONE: begin
               bus.mult_done     = 1'b1;
               bus.mult_busy     = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_hazard_ctrl.sv
// Random and directed checks of mult_hazard_ctrl at latencies 4 and 2.
module tb_mult_hazard_ctrl;

   localparam int unsigned AW = 5;

   logic clk = 1'b0;
   logic arst_n = 1'b0;

   logic          ex_valid, ex_is_mult, ex_mem_read;
   logic [AW-1:0] ex_rd, ex_rs1, ex_rs2, id_rs1, id_rs2, mem_rd, wb_rd;
   logic          mem_reg_write, wb_reg_write;

   int n_chk = 0;
   int n_err = 0;
   int ph4 = -1;   // cycle index inside an in-flight multiply, -1 when none
   int ph2 = -1;

   always #5 clk = ~clk;

   mult_hazard_ctrl_if #(.REG_ADDR_W(AW)) i4 ();
   mult_hazard_ctrl_if #(.REG_ADDR_W(AW)) i2 ();

   assign i4.ex_valid = ex_valid;           assign i2.ex_valid = ex_valid;
   assign i4.ex_is_mult = ex_is_mult;       assign i2.ex_is_mult = ex_is_mult;
   assign i4.ex_mem_read = ex_mem_read;     assign i2.ex_mem_read = ex_mem_read;
   assign i4.ex_rd = ex_rd;                 assign i2.ex_rd = ex_rd;
   assign i4.ex_rs1 = ex_rs1;               assign i2.ex_rs1 = ex_rs1;
   assign i4.ex_rs2 = ex_rs2;               assign i2.ex_rs2 = ex_rs2;
   assign i4.id_rs1 = id_rs1;               assign i2.id_rs1 = id_rs1;
   assign i4.id_rs2 = id_rs2;               assign i2.id_rs2 = id_rs2;
   assign i4.mem_rd = mem_rd;               assign i2.mem_rd = mem_rd;
   assign i4.wb_rd = wb_rd;                 assign i2.wb_rd = wb_rd;
   assign i4.mem_reg_write = mem_reg_write; assign i2.mem_reg_write = mem_reg_write;
   assign i4.wb_reg_write = wb_reg_write;   assign i2.wb_reg_write = wb_reg_write;

   mult_hazard_ctrl #(.REG_ADDR_W(AW), .MULT_LATENCY(4)) dut4 (
      .clk (clk), .arst_n (arst_n), .bus (i4.slave));
   mult_hazard_ctrl #(.REG_ADDR_W(AW), .MULT_LATENCY(2)) dut2 (
      .clk (clk), .arst_n (arst_n), .bus (i2.slave));

   // Count one comparison and report a mismatch
   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Expected forwarding select for one source register
   function automatic logic [1:0] exp_fwd(input logic [AW-1:0] rs);
      if (mem_reg_write && mem_rd != 0 && mem_rd == rs) return 2'b01;
      if (wb_reg_write && wb_rd != 0 && wb_rd == rs)    return 2'b10;
      return 2'b00;
   endfunction

   // Expected {start,done,busy,stall,flush,bubble}: a multiply spans lat cycles,
   // cycle 0 launches, 1..lat-2 hold, lat-1 completes
   function automatic logic [5:0] exp_ctl(input int ph, input int lat);
      if (!arst_n) return 6'b0;
      if (ph < 0) begin
         if (ex_valid && ex_is_mult) return 6'b100101;
         if (ex_valid && ex_mem_read && ex_rd != 0 && (ex_rd == id_rs1 || ex_rd == id_rs2))
            return 6'b000110;
         return 6'b0;
      end
      if (ph == lat - 1) return 6'b011000;
      return 6'b001101;
   endfunction

   function automatic int next_ph(input int ph, input int lat);
      if (!arst_n) return -1;
      if (ph < 0) return (ex_valid && ex_is_mult) ? 1 : -1;
      if (ph == lat - 1) return -1;
      return ph + 1;
   endfunction

   // Compare every output against the model
   task automatic cmp_all();
      check_val("ctl_l4", {i4.mult_start, i4.mult_done, i4.mult_busy, i4.stall,
                           i4.id_ex_flush, i4.ex_mem_bubble}, 32'(exp_ctl(ph4, 4)));
      check_val("ctl_l2", {i2.mult_start, i2.mult_done, i2.mult_busy, i2.stall,
                           i2.id_ex_flush, i2.ex_mem_bubble}, 32'(exp_ctl(ph2, 2)));
      check_val("fwd_a", 32'(i4.fwd_sel_a), 32'(exp_fwd(ex_rs1)));
      check_val("fwd_b", 32'(i4.fwd_sel_b), 32'(exp_fwd(ex_rs2)));
   endtask

   task automatic at_neg();
      @(negedge clk);
      cmp_all();
   endtask

   task automatic to_next();
      @(posedge clk);
      ph4 = next_ph(ph4, 4);
      ph2 = next_ph(ph2, 2);
      #1;
   endtask

   task automatic idle_in();
      ex_valid = 0; ex_is_mult = 0; ex_mem_read = 0;
      ex_rd = 0; ex_rs1 = 0; ex_rs2 = 0; id_rs1 = 0; id_rs2 = 0;
      mem_rd = 0; wb_rd = 0; mem_reg_write = 0; wb_reg_write = 0;
   endtask

   task automatic mult_in();
      idle_in();
      ex_valid = 1; ex_is_mult = 1;
   endtask

   initial begin
      idle_in();
      // Reset state
      #2;
      check_val("rst_stall", 32'(i4.stall), 0);
      check_val("rst_busy", 32'(i4.mult_busy), 0);
      ex_valid = 1; ex_is_mult = 1;
      #1;
      check_val("rst_start_gated", 32'(i4.mult_start), 0);
      idle_in();
      @(posedge clk); #1;
      arst_n = 1;

      // Forwarding: MEM over WB, x0 never forwards
      mem_reg_write = 1; mem_rd = 5; wb_reg_write = 1; wb_rd = 5; ex_rs1 = 5;
      #1 check_val("fwd_mem_pri", 32'(i4.fwd_sel_a), 32'h1);
      mem_rd = 0; wb_rd = 0; ex_rs1 = 0;
      #1 check_val("fwd_x0", 32'(i4.fwd_sel_a), 32'h0);
      mem_reg_write = 0; wb_rd = 9; ex_rs2 = 9;
      #1 check_val("fwd_wb_b", 32'(i4.fwd_sel_b), 32'h2);
      at_neg(); to_next();

      // Single multiply, lat 4: start T, stall T..T+2, done T+3
      mult_in();
      at_neg(); check_val("m_start_T", 32'(i4.mult_start), 1); check_val("m_stall_T", 32'(i4.stall), 1); to_next();
      at_neg(); check_val("m_stall_T1", 32'(i4.stall), 1); to_next();
      at_neg(); check_val("m_stall_T2", 32'(i4.stall), 1); check_val("m_done_T2", 32'(i4.mult_done), 0); to_next();
      at_neg(); check_val("m_done_T3", 32'(i4.mult_done), 1); check_val("m_stall_T3", 32'(i4.stall), 0); to_next();
      idle_in();
      at_neg(); check_val("m_busy_T4", 32'(i4.mult_busy), 0); to_next();

      // Back-to-back multiplies: second start at T+4, done at T+7
      mult_in();
      for (int c = 0; c < 8; c++) begin
         at_neg();
         check_val($sformatf("b2b_start_%0d", c), 32'(i4.mult_start), (c == 0 || c == 4) ? 1 : 0);
         check_val($sformatf("b2b_done_%0d", c), 32'(i4.mult_done), (c == 3 || c == 7) ? 1 : 0);
         to_next();
      end
      idle_in();
      at_neg(); to_next();
      at_neg(); to_next();

      // Load-use on id_rs2, then no hazard for x0 destination
      ex_valid = 1; ex_mem_read = 1; ex_rd = 7; id_rs2 = 7;
      at_neg(); check_val("lu_stall", 32'(i4.stall), 1); check_val("lu_flush", 32'(i4.id_ex_flush), 1); to_next();
      idle_in();
      at_neg(); check_val("lu_one_cycle", 32'(i4.stall), 0); to_next();
      ex_valid = 1; ex_mem_read = 1; ex_rd = 0; id_rs1 = 0;
      at_neg(); check_val("lu_x0", 32'(i4.stall), 0); to_next();
      ex_valid = 0; ex_rd = 3; id_rs1 = 3;
      at_neg(); check_val("lu_invalid", 32'(i4.stall), 0); to_next();
      // Multiply and load together: multiply wins, no flush
      ex_valid = 1; ex_is_mult = 1;
      at_neg(); check_val("mw_start", 32'(i4.mult_start), 1); check_val("mw_flush", 32'(i4.id_ex_flush), 0); to_next();
      // Load-use must be ignored while the multiply is in flight
      at_neg(); check_val("mw_busy_flush", 32'(i4.id_ex_flush), 0); to_next();
      idle_in();
      for (int c = 0; c < 3; c++) begin at_neg(); to_next(); end

      // Reset one cycle into a multiply abandons it
      mult_in();
      at_neg(); to_next();
      #2 arst_n = 0;
      #1;
      check_val("ar_stall", 32'(i4.stall), 0);
      check_val("ar_bubble", 32'(i4.ex_mem_bubble), 0);
      check_val("ar_busy", 32'(i4.mult_busy), 0);
      ph4 = -1; ph2 = -1;
      at_neg(); to_next();
      idle_in();
      arst_n = 1;
      ex_valid = 1; ex_mem_read = 1; ex_rd = 4; id_rs1 = 4;
      at_neg(); check_val("ar_first_lu", 32'(i4.id_ex_flush), 1); to_next();
      idle_in();
      for (int c = 0; c < 5; c++) begin
         at_neg(); check_val($sformatf("ar_no_done_%0d", c), 32'(i4.mult_done), 0); to_next();
      end

      // Randomized traffic against the model
      for (int c = 0; c < 600; c++) begin
         ex_valid      = ($urandom_range(0, 3) != 0);
         ex_is_mult    = ($urandom_range(0, 5) == 0);
         ex_mem_read   = ($urandom_range(0, 2) == 0);
         ex_rd         = AW'($urandom_range(0, 7));
         ex_rs1        = AW'($urandom_range(0, 7));
         ex_rs2        = AW'($urandom_range(0, 7));
         id_rs1        = AW'($urandom_range(0, 7));
         id_rs2        = AW'($urandom_range(0, 7));
         mem_rd        = AW'($urandom_range(0, 7));
         wb_rd         = AW'($urandom_range(0, 7));
         mem_reg_write = 1'($urandom_range(0, 1));
         wb_reg_write  = 1'($urandom_range(0, 1));
         at_neg();
         to_next();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
